spike_count_classifier: RTL and testbench

SPIKE_COUNT_CLASSIFIER -- requirements
Module: spike_count_classifier

---
 rtl/spike_count_classifier.sv | 137 +++++++++++++
 tb/tb_spike_count_classifier.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_count_classifier.sv
// Purpose: counts spikes per output line over a fixed window and reports the line with the most spikes.
// Latency: result_valid rises WINDOW+NUM_OUTPUTS edges after the edge that accepts start.
// Backpressure: the result is held in DONE until result_ready; start is ignored until the block is back in IDLE.
//
// Ports:
//   clk, rst           clock and asynchronous active-low reset
//   start              begin one window (sampled only in IDLE)
//   spike_in           one spike bit per network output neuron
//   busy               high in COUNT, COMPARE and DONE
//   result_valid       high in DONE; result_ready completes the handshake
//   class_out          index of the winning line (lowest index on ties)
//   count_out          spike count of the winning line
//   no_spike           every line counted zero in the window
module spike_count_classifier #(
  parameter int NUM_OUTPUTS = 1,
  parameter int WINDOW      = 100,
  parameter int COUNT_WIDTH = 8,
  localparam int CLASS_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_OUTPUTS-1:0] spike_in,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [CLASS_WIDTH-1:0] class_out,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   no_spike
);

  localparam logic [15:0]            TIMER_LOAD = 16'(WINDOW - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = {COUNT_WIDTH{1'b1}};
  localparam logic [CLASS_WIDTH-1:0] LAST_IDX   = CLASS_WIDTH'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [COUNT_WIDTH-1:0] cnt [NUM_OUTPUTS];
  logic [15:0]            timer;
  logic [CLASS_WIDTH-1:0] scan_idx;
  logic [COUNT_WIDTH-1:0] best_cnt;
  logic [CLASS_WIDTH-1:0] best_idx;

  // Running-best candidate including the counter scanned this cycle. Strict
  // greater-than keeps the earlier (lower) index on ties.
  logic                   cand_gt;
  logic [COUNT_WIDTH-1:0] cand_cnt;
  logic [CLASS_WIDTH-1:0] cand_idx;
  logic                   last_scan;

  assign cand_gt   = cnt[scan_idx] > best_cnt;
  assign cand_cnt  = cand_gt ? cnt[scan_idx] : best_cnt;
  assign cand_idx  = cand_gt ? scan_idx : best_idx;
  assign last_scan = (scan_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = COUNT;
      end
      COUNT: begin
        busy = 1'b1;
        if (timer == 16'd0) state_d = COMPARE;
      end
      COMPARE: begin
        busy = 1'b1;
        if (last_scan) state_d = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt[i] <= '0;
      timer     <= '0;
      scan_idx  <= '0;
      best_cnt  <= '0;
      best_idx  <= '0;
      class_out <= '0;
      count_out <= '0;
      no_spike  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) cnt[i] <= '0;
            timer <= TIMER_LOAD;
          end
        end
        COUNT: begin
          for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (spike_in[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + COUNT_WIDTH'(1);
          end
          if (timer != 16'd0) timer <= timer - 16'd1;
          // Prime the scan so COMPARE starts from index 0 with an empty best.
          scan_idx <= '0;
          best_cnt <= '0;
          best_idx <= '0;
        end
        COMPARE: begin
          best_cnt <= cand_cnt;
          best_idx <= cand_idx;
          scan_idx <= scan_idx + CLASS_WIDTH'(1);
          if (last_scan) begin
            // An all-zero window leaves best at index 0 / count 0.
            class_out <= cand_idx;
            count_out <= cand_cnt;
            no_spike  <= (cand_cnt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Directed bench for spike_count_classifier: two instances (4-bit and 3-bit
// counters) share the same stimulus; the 3-bit one is checked for saturation.
module tb_spike_count_classifier;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] spike_in;
  logic       result_ready;

  logic       busy, result_valid, no_spike;
  logic [1:0] class_out;
  logic [3:0] count_out;

  logic       busy_s, result_valid_s, no_spike_s;
  logic [1:0] class_out_s;
  logic [2:0] count_out_s;

  int n_assert;
  int n_fail;
  int cyc;
  int accept_cyc;
  int lat;
  logic [3:0] pat [10];

  spike_count_classifier #(.NUM_OUTPUTS(4), .WINDOW(10), .COUNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .class_out(class_out), .count_out(count_out), .no_spike(no_spike)
  );

  spike_count_classifier #(.NUM_OUTPUTS(4), .WINDOW(10), .COUNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
    .busy(busy_s), .result_valid(result_valid_s), .result_ready(result_ready),
    .class_out(class_out_s), .count_out(count_out_s), .no_spike(no_spike_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; start is seen by the next posedge (accept edge).
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    accept_cyc = cyc;
    start = 1'b0;
  endtask

  // Drives pat[] on the ten window edges, then tail afterwards.
  task automatic count_window(input logic [3:0] tail);
    for (int k = 0; k < 10; k++) begin
      spike_in = pat[k];
      @(negedge clk);
    end
    spike_in = tail;
  endtask

  task automatic wait_valid(output int latency);
    int n;
    n = 0;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    latency = cyc - accept_cyc;
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  initial begin
    bit seen_valid;
    bit seen_busy;
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    start        = 1'b0;
    spike_in     = 4'b0000;
    result_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_class", 32'(class_out), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_nospike", 32'(no_spike), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic: line 2 spikes every cycle, input kept high past the window
    spike_in = 4'b0100;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 10; k++) pat[k] = 4'b0100;
    do_start();
    chk("basic_busy", 32'(busy), 32'd1);
    count_window(4'b0100);
    chk("basic_not_early", 32'(result_valid), 32'd0);
    wait_valid(lat);
    chk("basic_valid", 32'(result_valid), 32'd1);
    chk("basic_latency", 32'(lat), 32'd14);
    chk("basic_class", 32'(class_out), 32'd2);
    chk("basic_count", 32'(count_out), 32'd10);
    chk("basic_nospike", 32'(no_spike), 32'd0);
    handshake();
    chk("basic_post_valid", 32'(result_valid), 32'd0);
    chk("basic_post_busy", 32'(busy), 32'd0);
    chk("basic_post_class", 32'(class_out), 32'd2);

    // Tie: lines 1 and 3 spike 5 times each
    for (int k = 0; k < 10; k++) pat[k] = (k < 5) ? 4'b1010 : 4'b0000;
    do_start();
    count_window(4'b1111);
    wait_valid(lat);
    chk("tie_latency", 32'(lat), 32'd14);
    chk("tie_class", 32'(class_out), 32'd1);
    chk("tie_count", 32'(count_out), 32'd5);
    chk("tie_nospike", 32'(no_spike), 32'd0);
    handshake();

    // Silence
    for (int k = 0; k < 10; k++) pat[k] = 4'b0000;
    do_start();
    count_window(4'b1111);
    wait_valid(lat);
    chk("silent_valid", 32'(result_valid), 32'd1);
    chk("silent_nospike", 32'(no_spike), 32'd1);
    chk("silent_class", 32'(class_out), 32'd0);
    chk("silent_count", 32'(count_out), 32'd0);
    handshake();

    // Saturation: line 0 high 10 cycles, line 1 high 6 cycles
    for (int k = 0; k < 10; k++) pat[k] = (k < 6) ? 4'b0011 : 4'b0001;
    do_start();
    count_window(4'b1111);
    wait_valid(lat);
    chk("sat4_class", 32'(class_out), 32'd0);
    chk("sat4_count", 32'(count_out), 32'd10);
    chk("sat3_valid", 32'(result_valid_s), 32'd1);
    chk("sat3_class", 32'(class_out_s), 32'd0);
    chk("sat3_count", 32'(count_out_s), 32'd7);
    chk("sat3_nospike", 32'(no_spike_s), 32'd0);
    handshake();

    // Backpressure: line 3 wins, result held 20 cycles with start toggling
    for (int k = 0; k < 10; k++) pat[k] = 4'b1000;
    do_start();
    count_window(4'b1111);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd14);
    for (int k = 0; k < 20; k++) begin
      start = ~start;
      @(negedge clk);
      chk("bp_valid", 32'(result_valid), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_class", 32'(class_out), 32'd3);
      chk("bp_count", 32'(count_out), 32'd10);
    end
    start = 1'b0;
    handshake();
    chk("bp_idle_valid", 32'(result_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_hold_class", 32'(class_out), 32'd3);

    // Back-to-back start right after the handshake: line 1 wins
    for (int k = 0; k < 10; k++) pat[k] = 4'b0010;
    do_start();
    chk("b2b_busy", 32'(busy), 32'd1);
    count_window(4'b1111);
    wait_valid(lat);
    chk("b2b_latency", 32'(lat), 32'd14);
    chk("b2b_class", 32'(class_out), 32'd1);
    chk("b2b_count", 32'(count_out), 32'd10);
    handshake();

    // Reset mid-window at window cycle 5
    for (int k = 0; k < 10; k++) pat[k] = 4'b0100;
    do_start();
    for (int k = 0; k < 5; k++) begin
      spike_in = pat[k];
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_valid", 32'(result_valid), 32'd0);
    chk("mrst_class", 32'(class_out), 32'd0);
    chk("mrst_count", 32'(count_out), 32'd0);
    chk("mrst_nospike", 32'(no_spike), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    seen_busy  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (result_valid) seen_valid = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    chk("mrst_no_valid", 32'(seen_valid), 32'd0);
    chk("mrst_needs_start", 32'(seen_busy), 32'd0);

    // Fresh window after reset: line 0 three spikes, line 2 seven spikes
    for (int k = 0; k < 10; k++) pat[k] = (k < 3) ? 4'b0101 : ((k < 7) ? 4'b0100 : 4'b0000);
    do_start();
    count_window(4'b1111);
    wait_valid(lat);
    chk("fresh_latency", 32'(lat), 32'd14);
    chk("fresh_class", 32'(class_out), 32'd2);
    chk("fresh_count", 32'(count_out), 32'd7);
    chk("fresh_nospike", 32'(no_spike), 32'd0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
